rom_streamer: RTL
=================

# rom_streamer

Address sequencer that sits directly upstream of the team's 128×16 synchronous ROM. It walks a programmed address range, issues one ROM address per cycle, and absorbs the ROM's registered read latency. It presents each fetched word to a downstream consumer (display scanner, UART transmitter) over a valid/ready stream. A small internal FIFO keeps full throughput under backpressure, with no lost or duplicated words.

## Interface
- ADDR_W, 7, ROM address width (depth 2^ADDR_W = 128)
- DATA_W, 16, ROM word width
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  one-cycle request to begin a pass; ignored while busy
- abort  in  1  synchronous flush; returns to IDLE next edge, no done pulse
- start_addr  in  ADDR_W  first address, sampled when start accepted
- last_addr  in  ADDR_W  final address (inclusive), sampled when start accepted
- rom_addr  out  ADDR_W  address to ROM; registered
- rom_data  in  DATA_W  ROM output, valid one cycle after rom_addr changes
- out_data  out  DATA_W  stream word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_last  out  1  qualifies the word fetched from last_addr
- busy  out  1  high from accepted start until done or abort
- done  out  1  one-cycle pulse after final word handshake

## Operation
- Reset values: rom_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, FIFO empty, state IDLE.
- States:
  - IDLE: start → FETCH, latch range, busy=1.
  - FETCH: issue addresses; after issuing last_addr → DRAIN.
  - DRAIN: wait for FIFO empty and in-flight zero, with final handshake → IDLE, done=1.
  - abort from any state → IDLE.
- Address walk increments modulo 2^ADDR_W. A range with start_addr > last_addr wraps 127→0. start_addr == last_addr yields exactly one word. Word count = ((last_addr − start_addr) mod 128) + 1, range 1..128.
- Issue rule: advance rom_addr only when (FIFO occupancy + in-flight reads) < FIFO_DEPTH, where FIFO_DEPTH=4. Pops in the same cycle are not credited. The FIFO never overflows.
- In-flight tracking is a 2-stage valid/last shift register aligned with the rom_addr register and the ROM output register. Stage 2 writes {rom_data, last} into the FIFO.
- FIFO head drives out_data/out_valid/out_last. Words leave strictly in address order.
- start while busy is ignored. start and abort in the same cycle: abort wins.
- abort discards FIFO contents and in-flight reads, and drops out_valid the next cycle. Late ROM data from aborted reads is never written.
- reset mid-pass has the same effect as abort but is asynchronous.

## Timing
- start sampled at edge E1 → rom_addr=start_addr after E1 → rom_data valid after E2 → FIFO write at E3 → out_valid high in the cycle after E3. First-word latency is 3 cycles.
- With out_ready held high: one word per cycle, no bubbles. A 128-word pass finishes its last handshake 130 cycles after start.
- out_ready low: at most 4 words buffered; issue stalls; rom_addr holds.
- done pulses in the cycle after the final handshake. busy falls on the same edge. A new start is accepted in the cycle done is high.
- out_data/out_last stay stable while out_valid && !out_ready.

## Configuration
- ROM_STREAM_LOOP_EN defined: adds input loop (1 bit, sampled with start).
  - With loop=1, after issuing last_addr the walk restarts at start_addr without entering DRAIN.
  - out_last marks every pass. done never pulses. Only abort/reset stop the stream.
- Not defined: no loop port; every pass is single-shot as above.

## Structure
- Package rom_stream_pkg: ADDR_W, DATA_W, FIFO_DEPTH=4, state enum {IDLE, FETCH, DRAIN}, FIFO entry type {data, last}.
- Sub-module stream_fifo: 4-entry synchronous FIFO with count, push/pop, flush, async reset. Sequencer FSM and in-flight pipeline stay in rom_streamer.

## Test plan
- start_addr=0, last_addr=3, out_ready=1 → words rom[0..3] on 4 consecutive cycles from cycle 3; out_last on rom[3]; done pulses next cycle.
- start_addr=126, last_addr=1 → order rom[126], rom[127], rom[0], rom[1]; out_last on rom[1].
- start_addr=5, last_addr=5, with out_ready toggling 0/1 randomly → single word rom[5]; no duplicates; data stable while stalled; rom_addr never passes 5.
- Full range 0..127, out_ready low for 20 cycles mid-pass → exactly 128 words in order; FIFO occupancy ≤4; last handshake at cycle 150.
- abort at cycle 10 of a 0..127 pass, then start 10..12 → out_valid low after abort; next stream is exactly rom[10..12].
- ROM_STREAM_LOOP_EN, loop=1, range 2..3 → rom[2], rom[3], rom[2], rom[3], … with out_last on each rom[3]; no done; reset mid-stream returns all outputs to reset values immediately.

Source files
------------

// File: rtl/rom_stream_pkg.sv
// Shared types and sizes for the ROM address streamer.
// Contents: ROM geometry (ADDR_W, DATA_W), output FIFO depth, sequencer state
// encoding, and the FIFO entry layout (word plus end-of-pass flag).
package rom_stream_pkg;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    // Wide enough for FIFO occupancy plus the two in-flight reads (max 6).
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } fifo_entry_t;

endpackage

// File: rtl/rom_streamer_fifo.sv
// stream_fifo: small synchronous FIFO holding fetched ROM words until the
// consumer takes them.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_entry write one entry (ignored when full)
//   pop             remove the head entry (ignored when empty)
//   flush           synchronous clear; overrides push and pop
//   head            entry at the head (meaningful only when count != 0)
//   count           number of stored entries
module stream_fifo
    import rom_stream_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  fifo_entry_t       push_entry,
    input  logic              pop,
    input  logic              flush,
    output fifo_entry_t       head,
    output logic [CNT_W-1:0]  count
);

    fifo_entry_t             mem_q [FIFO_DEPTH];
    fifo_entry_t             mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    do_push, do_pop;

    assign do_push = push && (count_q < CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/rom_streamer.sv
// rom_streamer: walks an inclusive ROM address range (wrapping mod 128),
// issues one address per cycle to a synchronous ROM, absorbs its one-cycle
// registered latency and streams the words out over valid/ready.
// Optional feature macro: ROM_STREAM_LOOP_EN adds input 'loop'; when set at
// start the walk repeats the range until abort/reset and never pulses done.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   start, abort            begin a pass (ignored while busy) / flush to IDLE
//   start_addr, last_addr   range, sampled when start is accepted
//   loop                    (ROM_STREAM_LOOP_EN only) repeat the range
//   rom_addr, rom_data      ROM address (registered) and ROM read data
//   out_data/valid/ready    output stream; out_last flags the last_addr word
//   busy, done              pass in progress / one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start, FIFO and pipeline empty
// FETCH | issuing addresses as FIFO credit allows
// DRAIN | all addresses issued, waiting for final handshake
module rom_streamer
    import rom_stream_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] last_addr,
`ifdef ROM_STREAM_LOOP_EN
    input  logic              loop,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [ADDR_W-1:0] range_start_q, range_start_d;
    logic [ADDR_W-1:0] range_last_q, range_last_d;
    logic              s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic              s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  fifo_count, occupancy;
    fifo_entry_t       fifo_head, push_entry;
    logic              issue_ok, start_ok, issue, hit_last, handshake, loop_sel;
    logic [ADDR_W-1:0] issue_addr, issue_last, issue_start;

`ifdef ROM_STREAM_LOOP_EN
    logic loop_q, loop_d;
    assign loop_d   = start_ok ? loop : loop_q;
    assign loop_sel = start_ok ? loop : loop_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) loop_q <= 1'b0;
        else       loop_q <= loop_d;
    end
`else
    assign loop_sel = 1'b0;
`endif

    // Same-cycle pops are not credited, so the FIFO can never overflow.
    assign occupancy = fifo_count + CNT_W'(s1_valid_q) + CNT_W'(s2_valid_q);
    assign issue_ok  = occupancy < CNT_W'(FIFO_DEPTH);
    assign start_ok  = start && !abort && (state_q == IDLE);
    assign issue     = start_ok || (!abort && (state_q == FETCH) && issue_ok);

    assign issue_addr  = start_ok ? start_addr : next_addr_q;
    assign issue_last  = start_ok ? last_addr  : range_last_q;
    assign issue_start = start_ok ? start_addr : range_start_q;
    assign hit_last    = issue && (issue_addr == issue_last);
    assign handshake   = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rom_addr_q    <= '0;
            next_addr_q   <= '0;
            range_start_q <= '0;
            range_last_q  <= '0;
            s1_valid_q    <= 1'b0;
            s1_last_q     <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_last_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rom_addr_q    <= rom_addr_d;
            next_addr_q   <= next_addr_d;
            range_start_q <= range_start_d;
            range_last_q  <= range_last_d;
            s1_valid_q    <= s1_valid_d;
            s1_last_q     <= s1_last_d;
            s2_valid_q    <= s2_valid_d;
            s2_last_q     <= s2_last_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (start_ok) state_d = (hit_last && !loop_sel) ? DRAIN : FETCH;
                FETCH: if (hit_last && !loop_sel) state_d = DRAIN;
                DRAIN: if (handshake && fifo_head.last) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rom_addr_d    = issue ? issue_addr : rom_addr_q;
        next_addr_d   = next_addr_q;
        range_start_d = start_ok ? start_addr : range_start_q;
        range_last_d  = start_ok ? last_addr  : range_last_q;
        if (issue) begin
            next_addr_d = (hit_last && loop_sel) ? issue_start : issue_addr + ADDR_W'(1);
        end
        // Two-stage tag pipeline: stage 1 aligns with rom_addr, stage 2 with
        // the ROM output register. Abort kills both so late data is dropped.
        s1_valid_d = issue;
        s1_last_d  = hit_last;
        s2_valid_d = s1_valid_q && !abort;
        s2_last_d  = s1_last_q;
        done_d     = !abort && (state_q == DRAIN) && handshake && fifo_head.last;
    end

    assign push_entry = '{data: rom_data, last: s2_last_q};

    stream_fifo u_fifo (
        .clk        (clk),
        .rst        (reset),
        .push       (s2_valid_q),
        .push_entry (push_entry),
        .pop        (handshake),
        .flush      (abort),
        .head       (fifo_head),
        .count      (fifo_count)
    );

    assign rom_addr  = rom_addr_q;
    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? fifo_head.data : '0;
    assign out_last  = out_valid && fifo_head.last;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
